crc32_mem_reader: RTL and testbench
===================================

CRC32_MEM_READER -- requirements
Module: crc32_mem_reader

Interface
REQ-001 clk  input  1  single clock for all logic.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle pulse; begins a CRC pass when IDLE.
REQ-004 abort  input  1  one-cycle pulse; cancels a pass in progress.
REQ-005 base_addr  input  10  first word address; sampled on start.
REQ-006 length  input  11  word count, 0..1024; sampled on start.
REQ-007 busy  output  1  high in RUN and DRAIN.
REQ-008 done  output  1  one-cycle pulse when the CRC result is valid.
REQ-009 crc  output  32  CRC-32 result; held until the next start.
REQ-010 mem_address  output  10  word address to the on-chip RAM port.
REQ-011 mem_chipselect  output  1  read strobe to the RAM.
REQ-012 mem_clken  output  1  RAM clock enable; equals mem_chipselect.
REQ-013 mem_write  output  1  constant 0.
REQ-014 mem_byteenable  output  4  constant 4'hF.
REQ-015 mem_readdata  input  32  RAM read data, valid exactly 1 cycle after the address is presented.

Function
REQ-016 States SHALL be IDLE, RUN, DRAIN and DONE.
- IDLE->RUN on start with length>0.
- IDLE->DONE on start with length==0.
- RUN->DRAIN when the last address is issued.
- DRAIN->DONE after one cycle.
- DONE->IDLE after one cycle.
REQ-017 On start, the block SHALL load addr=base_addr, remaining=length and state=32'hFFFFFFFF.
REQ-018 In RUN, every cycle SHALL drive mem_address=addr and mem_chipselect=1, then increment addr modulo 1024 and decrement remaining.
REQ-019 Address wrap SHALL go from 1023 to 0 with no error flag.
REQ-020 A valid flag SHALL be delayed one cycle from mem_chipselect; when it is set, the block SHALL fold mem_readdata into state.
- Algorithm: reflected CRC-32, polynomial 0xEDB88320.
- Order: 32 bits in one cycle, bit 0 first (byte 0 first, little-endian).
REQ-021 Throughput SHALL be 1 word per cycle; done SHALL assert exactly length+2 cycles after the start cycle, or 1 cycle after it when length==0.
REQ-022 In DONE, crc SHALL be updated from the final state per REQ-031/REQ-032 and done SHALL pulse for 1 cycle.
REQ-023 start while busy or in DONE SHALL be ignored.
REQ-024 abort in RUN or DRAIN SHALL return to IDLE next cycle.
- mem_chipselect deasserts that same next cycle.
- Neither done nor crc updates.
REQ-025 If abort and start occur together in IDLE, start SHALL win.
REQ-026 mem_chipselect SHALL be 0 in IDLE, DRAIN and DONE.

Reset
REQ-027 On reset_n low, the block SHALL immediately enter IDLE with busy=0, done=0, mem_chipselect=0 and mem_clken=0.
REQ-028 On reset_n low, crc, mem_address, addr, remaining and the valid flag SHALL clear to 0.
REQ-029 Reset mid-pass SHALL discard the pass; no done pulse follows.
REQ-030 Reset SHALL deassert with no output glitch; the first start is accepted on the first clk edge after release.

Configuration
REQ-031 With CRC_FINAL_XOR_EN defined, crc SHALL be state XOR 32'hFFFFFFFF (standard CRC-32).
REQ-032 Without CRC_FINAL_XOR_EN, crc SHALL be the raw state, with no final inversion.

Verification (CRC_FINAL_XOR_EN defined; 1-cycle-latency RAM model)
REQ-033 Word[0]=32'h00000000; start, base=0, length=1 -> crc=32'h2144DF1C, done 3 cycles after start.
REQ-034 Word[5]=32'h34333231 ("1234"); start, base=5, length=1 -> crc=32'h9BE3E0A3.
REQ-035 start with length=0 -> done 1 cycle later; crc=32'h00000000; mem_chipselect never asserted.
REQ-036 base=1022, length=4 -> mem_address sequence 1022,1023,0,1; crc matches the reference model over those 4 words.
REQ-037 length=8, abort on the 3rd RUN cycle -> IDLE next cycle, no done, crc unchanged; a second start during RUN is ignored.
REQ-038 reset_n pulsed low mid-RUN -> outputs zero immediately; a fresh start afterwards yields the correct CRC.

Source files
------------

// File: rtl/crc32_mem_reader.sv
// Streams a block of 32-bit words from on-chip RAM and folds them into a reflected CRC-32.
// Build option: define CRC_FINAL_XOR_EN to apply the standard final inversion to crc.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; RAM port quiet
// S_RUN    | one read issued per cycle, down-counter tracks words left
// S_DRAIN  | last read in flight; its data is folded this cycle
// S_DONE   | crc register holds the result, done pulses for one cycle
module crc32_mem_reader (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic [9:0]  base_addr,
   input  logic [10:0] length,
   output logic        busy,
   output logic        done,
   output logic [31:0] crc,
   output logic [9:0]  mem_address,
   output logic        mem_chipselect,
   output logic        mem_clken,
   output logic        mem_write,
   output logic [3:0]  mem_byteenable,
   input  logic [31:0] mem_readdata
);

   localparam logic [31:0] CRC_POLY = 32'hEDB88320;
`ifdef CRC_FINAL_XOR_EN
   localparam logic [31:0] FINAL_XOR = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] FINAL_XOR = 32'h0000_0000;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [9:0]  addr;
   logic [10:0] remaining;
   logic [31:0] crc_state;
   logic [31:0] crc_folded;
   logic [31:0] crc_final_src;
   logic [31:0] crc_q;
   logic        valid;
   logic        load_crc;

   // Whole word folded LSB first, which is byte 0 first for little-endian data.
   function automatic logic [31:0] crc_fold(input logic [31:0] s, input logic [31:0] d);
      logic [31:0] c;
      c = s ^ d;
      for (int i = 0; i < 32; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (length == 11'd0) ? S_DONE : S_RUN;
         S_RUN: begin
            if (abort)                    state_d = S_IDLE;
            else if (remaining == 11'd1)  state_d = S_DRAIN;
         end
         S_DRAIN: state_d = abort ? S_IDLE : S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy           = 1'b0;
      done           = 1'b0;
      mem_chipselect = 1'b0;
      case (state_q)
         S_RUN: begin
            busy           = 1'b1;
            mem_chipselect = 1'b1;
         end
         S_DRAIN: busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign crc_folded    = crc_fold(crc_state, mem_readdata);
   // A zero-length pass never touches crc_state, so it reports the seed directly.
   assign crc_final_src = (state_q == S_IDLE) ? 32'hFFFF_FFFF
                        : (valid ? crc_folded : crc_state);
   assign load_crc      = ((state_q == S_IDLE) && start && (length == 11'd0))
                        || ((state_q == S_DRAIN) && !abort);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr      <= '0;
         remaining <= '0;
         crc_state <= '0;
         valid     <= 1'b0;
         crc_q     <= '0;
      end else begin
         valid <= mem_chipselect;
         if ((state_q == S_IDLE) && start) begin
            addr      <= base_addr;
            remaining <= length;
            crc_state <= 32'hFFFF_FFFF;
         end else begin
            if (state_q == S_RUN) begin
               addr      <= addr + 10'd1;
               remaining <= remaining - 11'd1;
            end
            if (valid) crc_state <= crc_folded;
         end
         if (load_crc) crc_q <= crc_final_src ^ FINAL_XOR;
      end
   end

   assign crc            = crc_q;
   assign mem_address    = addr;
   assign mem_clken      = mem_chipselect;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;

endmodule

// File: tb/tb_crc32_mem_reader.sv
// Randomized bench for crc32_mem_reader with a 1-cycle-latency RAM and a byte-wise CRC-32 model.
module tb_crc32_mem_reader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic [9:0]  base_addr;
   logic [10:0] length;
   logic        busy;
   logic        done;
   logic [31:0] crc;
   logic [9:0]  mem_address;
   logic        mem_chipselect;
   logic        mem_clken;
   logic        mem_write;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata = 32'h0;

   logic [31:0] mem [1024];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] last_crc;

`ifdef CRC_FINAL_XOR_EN
   localparam logic [31:0] OUT_XOR = 32'h0000_0000;
   localparam logic        XOR_EN  = 1'b1;
`else
   localparam logic [31:0] OUT_XOR = 32'hFFFF_FFFF;
   localparam logic        XOR_EN  = 1'b0;
`endif

   crc32_mem_reader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .abort          (abort),
      .base_addr      (base_addr),
      .length         (length),
      .busy           (busy),
      .done           (done),
      .crc            (crc),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_clken      (mem_clken),
      .mem_write      (mem_write),
      .mem_byteenable (mem_byteenable),
      .mem_readdata   (mem_readdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) mem_readdata <= mem[mem_address];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Standard byte-serial CRC-32 over the words in memory order, bytes little-endian.
   function automatic logic [31:0] ref_crc(input int b, input int l);
      logic [31:0] c;
      logic [31:0] w;
      c = 32'hFFFF_FFFF;
      for (int k = 0; k < l; k++) begin
         w = mem[(b + k) % 1024];
         for (int by = 0; by < 4; by++) begin
            c = c ^ {24'h0, w[8*by +: 8]};
            for (int bit_i = 0; bit_i < 8; bit_i++) begin
               if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
               else      c = c >> 1;
            end
         end
      end
      return XOR_EN ? ~c : c;
   endfunction

   task automatic do_pass(input int b, input int l, input bit with_abort, input bit inject_start,
                          input string tag);
      int cycles;
      int words;
      logic [31:0] exp_crc;
      exp_crc = ref_crc(b, l);
      @(negedge clk);
      base_addr = 10'(b);
      length    = 11'(l);
      start     = 1'b1;
      abort     = with_abort;
      @(negedge clk);
      start  = 1'b0;
      abort  = 1'b0;
      cycles = 1;
      words  = 0;
      check({tag, "_busy"}, 32'(busy), 32'(l > 0));
      while (1) begin
         if (mem_chipselect) begin
            check({tag, "_addr"}, 32'(mem_address), 32'((b + words) % 1024));
            words++;
         end
         if (done || cycles > l + 4) break;
         @(negedge clk);
         cycles++;
         if (inject_start && cycles == 2) begin
            start     = 1'b1;
            base_addr = ~base_addr;
            length    = 11'd3;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check({tag, "_latency"}, done ? 32'(cycles) : 32'hDEAD, 32'((l == 0) ? 1 : l + 2));
      check({tag, "_words"}, 32'(words), 32'(l));
      check({tag, "_crc"}, crc, exp_crc);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(done), 32'h0);
      check({tag, "_hold"}, crc, exp_crc);
      last_crc = exp_crc;
   endtask

   initial begin
      int ndone;
      reset_n   = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      base_addr = '0;
      length    = '0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0] = 32'h0000_0000;
      mem[5] = 32'h3433_3231;
      #1;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_cs", 32'({mem_chipselect, mem_clken}), 32'h0);
      check("rst_crc", crc, 32'h0);
      check("rst_addr", 32'(mem_address), 32'h0);
      check("const_we_be", 32'({mem_write, mem_byteenable}), 32'h0F);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      do_pass(0, 1, 1'b0, 1'b0, "zero_word");
      check("known_zero", crc, 32'h2144DF1C ^ OUT_XOR);
      do_pass(5, 1, 1'b0, 1'b0, "ascii_1234");
      check("known_1234", crc, 32'h9BE3E0A3 ^ OUT_XOR);
      do_pass(1022, 4, 1'b0, 1'b0, "wrap");
      do_pass(100, 0, 1'b0, 1'b0, "len0");
      check("len0_value", crc, 32'h0000_0000 ^ OUT_XOR);
      do_pass(200, 6, 1'b1, 1'b0, "abort_start_idle");
      do_pass(300, 8, 1'b0, 1'b1, "restart_ignored");
      for (int r = 0; r < 6; r++) begin
         do_pass(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)), 1'b0, 1'b0, "rand");
      end
      do_pass(int'($urandom_range(0, 1023)), 1024, 1'b0, 1'b0, "full");

      // Abort on the third RUN cycle.
      @(negedge clk);
      base_addr = 10'd40;
      length    = 11'd8;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_cs", 32'(mem_chipselect), 32'h0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("abort_nodone", 32'(ndone), 32'h0);
      check("abort_crc", crc, last_crc);

      // Reset in the middle of a pass.
      base_addr = 10'd700;
      length    = 11'd8;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_cs", 32'({mem_chipselect, mem_clken}), 32'h0);
      check("midrst_crc", crc, 32'h0);
      check("midrst_addr", 32'(mem_address), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("midrst_nodone", 32'(ndone), 32'h0);
      do_pass(700, 8, 1'b0, 1'b0, "after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
